de4_sopc_clock_xing_req_arbiter: RTL and testbench
==================================================

Name: de4_sopc_clock_xing_req_arbiter

Overview:
- Shares one toggle-handshake channel of the SOPC clock-crossing bridge between NUM_REQ local requesters.
- A transfer starts by flipping xfer_toggle. The far-side edge-to-pulse logic converts that flip to a pulse. The far side replies by flipping ack_toggle.
- This block arbitrates round-robin, launches one transfer at a time, detects the ack edge internally, times out lost acks and returns a per-requester completion pulse.
- Lives in the master-side clock domain. ack_toggle arrives already synchronized.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, payload width per requester.
- TIMEOUT, 255, cycles to wait in WAIT_ACK before abort (1..2**16-1).

Ports:
- clock  input  1  single clock for the whole block.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  level request per requester. Held until that requester's grant or err pulse.
- req_data  input  NUM_REQ*DATA_W  payload; slice i belongs to requester i.
- grant  output  NUM_REQ  one-hot, one-cycle completion pulse (success or timeout).
- grant_err  output  1  qualifies grant: 1 means the transfer timed out.
- xfer_toggle  output  1  flips once per launched transfer.
- xfer_data  output  DATA_W  latched payload. Stable from the launch edge until the next launch.
- ack_toggle  input  1  far-side acknowledge toggle, synchronized.
- busy  output  1  high in LAUNCH and WAIT_ACK.
- spurious_ack  output  1  sticky flag: an ack edge was seen outside WAIT_ACK. Cleared only by reset.

Behaviour:
- Single clock domain. Reset is synchronous and active-high: clock and reset as named above.
- Reset values: state=IDLE, xfer_toggle=0, xfer_data=0, grant=0, grant_err=0, busy=0, spurious_ack=0, rr_ptr=0, timeout counter=0.
- During reset, ack_d1 loads ack_toggle, not 0. This prevents a false edge at reset release.
- Ack edge detection:
  - ack_d1 is a register following ack_toggle.
  - ack_edge = ack_toggle XOR ack_d1, combinational.
- IDLE:
  - If any req bit is set, pick the first set bit at or after rr_ptr, wrapping modulo NUM_REQ.
  - Latch the index and req_data slice. Go to LAUNCH.
- LAUNCH (1 cycle):
  - Flip xfer_toggle, drive xfer_data, clear the timeout counter, go to WAIT_ACK.
  - Latency: req sampled in cycle N causes the toggle flip visible at cycle N+2.
- WAIT_ACK:
  - If ack_edge: next cycle pulse grant[idx]=1 with grant_err=0, set rr_ptr=idx+1 (wrapping), go to IDLE.
  - Else if counter==TIMEOUT-1: next cycle pulse grant[idx] with grant_err=1, advance rr_ptr the same way, go to IDLE.
  - Else increment the counter.
  - If ack_edge and the timeout limit occur in the same cycle, ack wins (success).
- Grant cycle: FSM is in IDLE and may arbitrate in that same cycle. A requester must deassert req in the grant cycle, or it is eligible again. Round-robin guarantees it goes to the back of the queue.
- An ack_edge in IDLE or LAUNCH sets spurious_ack and is otherwise ignored. This includes a late ack after a timeout.
- Dropping req mid-transfer does not abort. The grant still pulses.
- Reset asserted mid-transfer aborts immediately with no grant. xfer_toggle returns to 0; the far side must be reset together with this block.

Decomposition:
- Shared package de4_sopc_clock_xing_pkg holds:
  - the state enum (IDLE, LAUNCH, WAIT_ACK);
  - the default TIMEOUT constant;
  - the function rr_pick(req, ptr), returning index and valid.
- One natural sub-module: de4_sopc_clock_xing_rr_arb, a combinational round-robin picker.
- Ack edge detection stays inline.

Test Plan:
- Single request: req=0001, data 0xDEADBEEF; ack_toggle flipped 5 cycles after xfer_toggle flips -> xfer_data=0xDEADBEEF, grant=0001 one cycle after the ack flip, grant_err=0, busy low afterwards.
- Fairness: req=1111 held and acked each time -> grant order 0,1,2,3,0. Each transfer produces exactly one xfer_toggle flip.
- Timeout: TIMEOUT=10, no ack -> grant pulse with grant_err=1 exactly 10 cycles after entering WAIT_ACK. Ack then flipped in IDLE -> spurious_ack=1.
- Simultaneous: ack flip on the cycle the counter hits TIMEOUT-1 -> grant_err=0.
- Reset: reset with ack_toggle=1, then release -> no spurious_ack and no grant. Reset during WAIT_ACK -> xfer_toggle=0, busy=0, no grant.

Source files
------------

// File: rtl/de4_sopc_clock_xing_pkg.sv
// Shared types and helpers for the clock-crossing request arbiter.
// rr_pick works on an 8-wide request vector so any NUM_REQ up to 8 can share it.
package de4_sopc_clock_xing_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LAUNCH   = 2'd1,
    WAIT_ACK = 2'd2
  } state_e;

  localparam int DEFAULT_TIMEOUT = 255;
  localparam int MAX_REQ         = 8;
  localparam int IDX_W           = 3;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                       input logic [IDX_W-1:0]   ptr,
                                       input int                 num_req);
    rr_pick_t         res;
    int               pos;
    logic [IDX_W-1:0] pos_idx;
    res = '0;
    // Scan farthest-first so the nearest set bit at/after ptr is written last.
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < num_req) begin
        pos     = (int'(ptr) + k) % num_req;
        pos_idx = pos[IDX_W-1:0];
        if (req[pos_idx]) begin
          res.vld = 1'b1;
          res.idx = pos_idx;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/de4_sopc_clock_xing_rr_arb.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module de4_sopc_clock_xing_rr_arb
  import de4_sopc_clock_xing_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               vld_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [MAX_REQ-1:0] req_ext;
  rr_pick_t           pick;

  always_comb begin
    req_ext              = '0;
    req_ext[NUM_REQ-1:0] = req_i;
    pick                 = rr_pick(req_ext, ptr_i, NUM_REQ);
  end

  assign vld_o = pick.vld;
  assign idx_o = pick.idx;

endmodule

// File: rtl/de4_sopc_clock_xing_req_arbiter.sv
// Shares one toggle-handshake crossing channel between NUM_REQ requesters:
// round-robin pick, one transfer in flight, ack-edge detect, timeout abort.
module de4_sopc_clock_xing_req_arbiter
  import de4_sopc_clock_xing_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      grant_err,
  output logic                      xfer_toggle,
  output logic [DATA_W-1:0]         xfer_data,
  input  logic                      ack_toggle,
  output logic                      busy,
  output logic                      spurious_ack
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, idx_q, idx_next;
  logic [DATA_W-1:0]    data_hold_q, xfer_data_q;
  logic                 xfer_toggle_q, ack_d1_q, spurious_q, grant_err_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [15:0]          cnt_q;
  logic                 ack_edge, timeout_hit, pick_vld;
  logic [IDX_W-1:0]     pick_idx;
  logic [DATA_W-1:0]    req_slice [MAX_REQ];

  for (genvar i = 0; i < MAX_REQ; i++) begin : g_slice
    if (i < NUM_REQ) begin : g_used
      assign req_slice[i] = req_data[i*DATA_W +: DATA_W];
    end else begin : g_unused
      assign req_slice[i] = '0;
    end
  end

  de4_sopc_clock_xing_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr_arb (
    .req_i (req),
    .ptr_i (rr_ptr_q),
    .vld_o (pick_vld),
    .idx_o (pick_idx)
  );

  assign ack_edge    = ack_toggle ^ ack_d1_q;
  assign timeout_hit = (cnt_q == TO_LAST);
  assign idx_next    = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (pick_vld) state_d = LAUNCH;
      LAUNCH:   state_d = WAIT_ACK;
      WAIT_ACK: if (ack_edge || timeout_hit) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == LAUNCH) || (state_q == WAIT_ACK);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      // Track the live ack level through reset so release never looks like an edge.
      ack_d1_q      <= ack_toggle;
      rr_ptr_q      <= '0;
      idx_q         <= '0;
      data_hold_q   <= '0;
      xfer_data_q   <= '0;
      xfer_toggle_q <= 1'b0;
      cnt_q         <= '0;
      grant_q       <= '0;
      grant_err_q   <= 1'b0;
      spurious_q    <= 1'b0;
    end else begin
      ack_d1_q    <= ack_toggle;
      grant_q     <= '0;
      grant_err_q <= 1'b0;
      if (ack_edge && (state_q != WAIT_ACK)) spurious_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            idx_q       <= pick_idx;
            data_hold_q <= req_slice[pick_idx];
          end
        end
        LAUNCH: begin
          xfer_toggle_q <= ~xfer_toggle_q;
          xfer_data_q   <= data_hold_q;
          cnt_q         <= '0;
        end
        WAIT_ACK: begin
          if (ack_edge || timeout_hit) begin
            grant_q     <= NUM_REQ'(1) << idx_q;
            grant_err_q <= ~ack_edge;
            rr_ptr_q    <= idx_next;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign grant        = grant_q;
  assign grant_err    = grant_err_q;
  assign xfer_toggle  = xfer_toggle_q;
  assign xfer_data    = xfer_data_q;
  assign spurious_ack = spurious_q;

endmodule

// File: tb/tb_de4_sopc_clock_xing_req_arbiter.sv
// Bench for the clock-crossing request arbiter: directed scenarios plus a
// randomized run against a round-robin / timing reference model.
module tb_de4_sopc_clock_xing_req_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int TO = 10;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [NR-1:0]    req = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]    grant;
  logic             grant_err;
  logic             xfer_toggle;
  logic [DW-1:0]    xfer_data;
  logic             ack_toggle = 1'b0;
  logic             busy;
  logic             spurious_ack;

  int vectors = 0;
  int errors  = 0;
  int model_ptr = 0;
  logic [DW-1:0] data_v [NR];

  de4_sopc_clock_xing_req_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .req_data     (req_data),
    .grant        (grant),
    .grant_err    (grant_err),
    .xfer_toggle  (xfer_toggle),
    .xfer_data    (xfer_data),
    .ack_toggle   (ack_toggle),
    .busy         (busy),
    .spurious_ack (spurious_ack)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req   = '0;
    repeat (3) step();
    reset = 1'b0;
    model_ptr = 0;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NR; i++) data_v[i] = $urandom;
    req_data = {data_v[3], data_v[2], data_v[1], data_v[0]};
  endtask

  function automatic int model_pick(input logic [NR-1:0] r);
    logic [1:0] j;
    for (int k = 0; k < NR; k++) begin
      j = 2'(model_ptr + k);
      if (r[j]) return int'(j);
    end
    return -1;
  endfunction

  // One transfer starting with the FSM in IDLE (or in a grant cycle). Returns in the grant cycle.
  task automatic do_xfer(input logic [NR-1:0] r, input int d, input bit ack_it,
                         input string tag, output int gidx);
    int            exp_idx, exp_t, n, t, extra_flips;
    bit            exp_err;
    logic          prev_tog;
    logic [DW-1:0] exp_dat;
    logic [NR-1:0] exp_g;
    exp_idx = model_pick(r);
    gidx    = exp_idx;
    exp_dat = data_v[exp_idx];
    exp_g   = NR'(1) << exp_idx;
    exp_err = !(ack_it && d < TO);
    exp_t   = exp_err ? TO : d + 1;
    req      = r;
    prev_tog = xfer_toggle;
    n = 0;
    while (xfer_toggle === prev_tog && n < 8) begin
      step();
      n++;
    end
    vectors++;
    if (n != 2) begin
      errors++;
      $display("FAIL %s launch_latency: got %0d cycles, want 2", tag, n);
      model_ptr = (exp_idx + 1) % NR;
      return;
    end
    vectors++;
    if (xfer_data !== exp_dat) begin
      errors++;
      $display("FAIL %s xfer_data: got %h, want %h", tag, xfer_data, exp_dat);
    end
    vectors++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_in_flight: got %b, want 1", tag, busy);
    end
    prev_tog    = xfer_toggle;
    extra_flips = 0;
    t = 0;
    while (t < 40) begin
      if (ack_it && t == d) ack_toggle = ~ack_toggle;
      step();
      t++;
      if (xfer_toggle !== prev_tog) extra_flips++;
      if (grant !== '0) break;
    end
    vectors++;
    if (t != exp_t) begin
      errors++;
      $display("FAIL %s grant_time: got %0d cycles, want %0d", tag, t, exp_t);
    end
    vectors++;
    if (grant !== exp_g || grant_err !== exp_err) begin
      errors++;
      $display("FAIL %s grant: got %b err %b, want %b err %b", tag, grant, grant_err, exp_g, exp_err);
    end
    vectors++;
    if (busy !== 1'b0 || extra_flips != 0) begin
      errors++;
      $display("FAIL %s grant_cycle: busy %b extra_flips %0d, want busy 0 flips 0", tag, busy, extra_flips);
    end
    model_ptr = (exp_idx + 1) % NR;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if (grant !== '0 || grant_err !== 1'b0 || xfer_toggle !== 1'b0 || xfer_data !== '0 ||
        busy !== 1'b0 || spurious_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: grant %b err %b tog %b data %h busy %b spur %b, want all 0",
               grant, grant_err, xfer_toggle, xfer_data, busy, spurious_ack);
    end
  endtask

  task automatic test_single();
    int g;
    apply_reset();
    rand_data();
    data_v[0] = 32'hDEADBEEF;
    req_data = {data_v[3], data_v[2], data_v[1], data_v[0]};
    do_xfer(4'b0001, 5, 1'b1, "single", g);
    req = '0;
    step();
    vectors++;
    if (busy !== 1'b0 || grant !== '0) begin
      errors++;
      $display("FAIL single_after: busy %b grant %b, want 0 0", busy, grant);
    end
  endtask

  task automatic test_fairness();
    int g;
    int exp_order [5] = '{0, 1, 2, 3, 0};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      rand_data();
      do_xfer(4'b1111, 3, 1'b1, "fair", g);
      vectors++;
      if (g != exp_order[i]) begin
        errors++;
        $display("FAIL fair_order[%0d]: got %0d, want %0d", i, g, exp_order[i]);
      end
    end
    req = '0;
    step();
  endtask

  task automatic test_timeout();
    int g;
    apply_reset();
    rand_data();
    do_xfer(4'b0010, 0, 1'b0, "timeout", g);
    req = '0;
    repeat (2) step();
    vectors++;
    if (spurious_ack !== 1'b0) begin
      errors++;
      $display("FAIL timeout_spur_pre: got %b, want 0", spurious_ack);
    end
    ack_toggle = ~ack_toggle;
    step();
    vectors++;
    if (spurious_ack !== 1'b1 || grant !== '0) begin
      errors++;
      $display("FAIL late_ack_spurious: spur %b grant %b, want 1 0000", spurious_ack, grant);
    end
  endtask

  task automatic test_simultaneous();
    int g;
    apply_reset();
    rand_data();
    do_xfer(4'b1000, TO - 1, 1'b1, "simul", g);
    req = '0;
    step();
  endtask

  task automatic test_reset_cases();
    int   n;
    logic prev_tog;
    ack_toggle = 1'b1;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (spurious_ack !== 1'b0 || grant !== '0) begin
        errors++;
        $display("FAIL reset_release[%0d]: spur %b grant %b, want 0 0000", i, spurious_ack, grant);
      end
    end
    rand_data();
    req      = 4'b0100;
    prev_tog = xfer_toggle;
    n = 0;
    while (xfer_toggle === prev_tog && n < 8) begin
      step();
      n++;
    end
    repeat (3) step();
    reset = 1'b1;
    req   = '0;
    step();
    vectors++;
    if (xfer_toggle !== 1'b0 || busy !== 1'b0 || grant !== '0) begin
      errors++;
      $display("FAIL reset_mid: tog %b busy %b grant %b, want 0 0 0000", xfer_toggle, busy, grant);
    end
    step();
    reset = 1'b0;
    model_ptr = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (grant !== '0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_after[%0d]: grant %b busy %b, want 0000 0", i, grant, busy);
      end
    end
  endtask

  task automatic test_random();
    int            g, d;
    bit            ack_it;
    logic [NR-1:0] r;
    apply_reset();
    r = '0;
    for (int i = 0; i < 30; i++) begin
      r = r | NR'($urandom_range(0, 15));
      if (r == '0) r = NR'(1) << $urandom_range(0, NR - 1);
      ack_it = ($urandom_range(0, 4) != 0);
      d      = $urandom_range(0, TO - 1);
      rand_data();
      do_xfer(r, d, ack_it, "random", g);
      r = r & ~(NR'(1) << g);
    end
    req = '0;
    step();
    vectors++;
    if (spurious_ack !== 1'b0) begin
      errors++;
      $display("FAIL random_spur: got %b, want 0", spurious_ack);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_simultaneous();
    test_reset_cases();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
